// File: rtl/des_sbox_if.sv
// Handshake bundle for the DES substitution stage: input word, result word,
// cancel and status.
interface des_sbox_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:48] in_data;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [1:32] out_data;
    logic        busy;

    // Producer/consumer side (round datapath)
    modport master (
        output in_valid,
        output in_data,
        output abort,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    // Substitution unit side
    modport slave (
        input  in_valid,
        input  in_data,
        input  abort,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

// File: rtl/des_sbox_unit.sv
// DES S-box stage: maps a 48-bit key-mixed word through S1..S8 into the
// 32-bit word feeding P. LANES lookups are done per cycle, so one word
// takes 8/LANES passes.
module des_sbox_unit #(
    parameter int LANES = 8
) (
    input logic          clk,
    input logic          rst_n,
    des_sbox_if.slave    bus
);

    localparam int PASSES = 8 / LANES;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
            $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    // One 64-bit word per (box,row); nibble 0 (column 0) is the leftmost.
    localparam logic [63:0] SBOX_ROM [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    // Row = outer bits {b1,b6}, column = inner bits b2..b5.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] six);
        logic [63:0] row_word;
        int          sh;
        row_word = SBOX_ROM[{box, six[5], six[0]}];
        sh       = 60 - 4 * int'(six[4:1]);
        return row_word[sh +: 4];
    endfunction

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [PASS_W-1:0] pass;
    logic [47:0]       hold;
    logic [31:0]       out_reg;
    logic              out_valid_r;
    logic              busy_r;
    logic [3:0]        lane_res [LANES];
    logic              accept;

    // Abort always blocks acceptance; DONE accepts only when its result leaves.
    assign bus.in_ready  = !bus.abort && ((state == IDLE) || ((state == DONE) && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_reg;
    assign bus.busy      = busy_r;

    // Lane l in the current pass serves S-box pass*LANES+l.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_res[l] = sbox_lookup(3'(int'(pass) * LANES + l),
                                      hold[47 - 6 * (int'(pass) * LANES + l) -: 6]);
        end
    end

    // Control FSM, holding register and nibble-group writes to the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pass        <= '0;
            hold        <= '0;
            out_reg     <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold   <= bus.in_data;
                        pass   <= '0;
                        busy_r <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.abort) begin
                        pass   <= '0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        for (int l = 0; l < LANES; l++) begin
                            out_reg[31 - 4 * (int'(pass) * LANES + l) -: 4] <= lane_res[l];
                        end
                        if (pass == LAST_PASS) begin
                            pass        <= '0;
                            busy_r      <= 1'b0;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            pass <= pass + PASS_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.abort) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (accept) begin
                            hold   <= bus.in_data;
                            pass   <= '0;
                            busy_r <= 1'b1;
                            state  <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_sbox_unit.sv
// Directed and streaming bench for des_sbox_unit at LANES = 1, 2, 4, 8.
module tb_des_sbox_unit;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv   [4];
    logic        ir   [4];
    logic        ab   [4];
    logic        ov   [4];
    logic        ordy [4];
    logic        bsy  [4];
    logic [47:0] idat [4];
    logic [31:0] odat [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // DUT index d runs with LANES = 1 << d.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_if sif ();
        assign sif.in_valid  = iv[g];
        assign sif.in_data   = idat[g];
        assign sif.abort     = ab[g];
        assign sif.out_ready = ordy[g];
        assign ir[g]   = sif.in_ready;
        assign ov[g]   = sif.out_valid;
        assign odat[g] = sif.out_data;
        assign bsy[g]  = sif.busy;
        des_sbox_unit #(.LANES(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sif.slave)
        );
    end

    // Standard DES tables, box-major, row-major, decimal.
    int unsigned SB [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
    };

    function automatic logic [31:0] model(input logic [47:0] x);
        logic [31:0] r;
        logic [5:0]  s;
        int          row;
        int          col;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            s   = x[47 - 6 * k -: 6];
            row = int'({s[5], s[0]});
            col = int'(s[4:1]);
            r[31 - 4 * k -: 4] = 4'(SB[k * 64 + row * 16 + col]);
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Send one word to an idle DUT, wait for its result, then consume it.
    task automatic xfer(input int d, input logic [47:0] din,
                        output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clk);
        iv[d] = 1'b1; idat[d] = din; ordy[d] = 1'b0;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        lat = 0; bcnt = 0;
        while (!ov[d] && lat < 40) begin
            if (bsy[d]) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = odat[d];
        @(negedge clk);
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d);
        int n;
        n = 0;
        while (!ov[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("wait_valid", ov[d], 1'b1);
    endtask

    logic [31:0] res;
    logic [31:0] snap;
    logic [47:0] din;
    int          lat;
    int          bcnt;
    int          seen;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; ab[i] = 1'b0; ordy[i] = 1'b0; idat[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("rst_in_ready", ir[i], 1'b1);
            check_eq("rst_out_valid", ov[i], 1'b0);
            check_eq("rst_busy", bsy[i], 1'b0);
            check_eq("rst_out_data", odat[i], 32'h0);
        end

        // Zero vector, single pass
        xfer(3, 48'h0, res, lat, bcnt);
        check_eq("zero_data", res, 32'hEFA72C4D);
        check_eq("zero_lat", lat, 1);
        check_eq("zero_busy_cycles", bcnt, 1);

        // All-ones vector, eight passes
        xfer(0, 48'hFFFF_FFFF_FFFF, res, lat, bcnt);
        check_eq("ones_data", res, 32'hD9CE3DCB);
        check_eq("ones_lat", lat, 8);
        check_eq("ones_busy_cycles", bcnt, 8);

        // S7 fed all ones, others zero
        xfer(3, 48'h3F << 6, res, lat, bcnt);
        check_eq("s7_ones_nibble", res[7:4], 4'hC);
        check_eq("s7_ones_word", res, 32'hEFA72CCD);

        // Every 6-bit value through every S-box position for every LANES
        for (int d = 0; d < 4; d++) begin
            for (int pos = 0; pos < 8; pos++) begin
                for (int v = 0; v < 64; v++) begin
                    din = 48'(v) << (42 - 6 * pos);
                    xfer(d, din, res, lat, bcnt);
                    check_eq("sweep", res, model(din));
                end
            end
        end

        // Backpressure in DONE, then back-to-back accept on release
        @(negedge clk);
        iv[2] = 1'b1; idat[2] = 48'h0123_4567_89AB; ordy[2] = 1'b0;
        @(posedge clk); #1;
        iv[2] = 1'b0;
        wait_valid(2);
        snap = odat[2];
        check_eq("bp_first", snap, model(48'h0123_4567_89AB));
        @(negedge clk);
        iv[2] = 1'b1; idat[2] = 48'hFEDC_BA98_7654;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check_eq("bp_hold_data", odat[2], snap);
            check_eq("bp_hold_valid", ov[2], 1'b1);
            check_eq("bp_in_ready", ir[2], 1'b0);
        end
        @(negedge clk);
        ordy[2] = 1'b1;
        #1;
        check_eq("bp_release_ready", ir[2], 1'b1);
        @(posedge clk); #1;
        iv[2] = 1'b0; ordy[2] = 1'b0;
        check_eq("bp_accept_busy", bsy[2], 1'b1);
        check_eq("bp_accept_valid", ov[2], 1'b0);
        wait_valid(2);
        check_eq("bp_second", odat[2], model(48'hFEDC_BA98_7654));
        @(negedge clk); ordy[2] = 1'b1;
        @(posedge clk); #1; ordy[2] = 1'b0;

        // Abort at pass 2 with a simultaneous input offer
        @(negedge clk);
        iv[1] = 1'b1; idat[1] = 48'hA5A5_5A5A_C3C3;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        ab[1] = 1'b1; iv[1] = 1'b1; idat[1] = 48'h1111_2222_3333;
        #1;
        check_eq("abort_in_ready", ir[1], 1'b0);
        @(posedge clk); #1;
        check_eq("abort_busy", bsy[1], 1'b0);
        check_eq("abort_valid", ov[1], 1'b0);
        @(negedge clk);
        ab[1] = 1'b0; iv[1] = 1'b0;
        #1;
        check_eq("abort_idle_ready", ir[1], 1'b1);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov[1] || bsy[1]) seen++;
        end
        check_eq("abort_quiet", seen, 0);

        // Abort in IDLE blocks a handshake but otherwise does nothing
        @(negedge clk);
        ab[1] = 1'b1; iv[1] = 1'b1; idat[1] = 48'h1111_2222_3333;
        #1;
        check_eq("abort_idle_block", ir[1], 1'b0);
        @(posedge clk); #1;
        check_eq("abort_idle_busy", bsy[1], 1'b0);
        @(negedge clk);
        ab[1] = 1'b0; iv[1] = 1'b0;
        xfer(1, 48'h1111_2222_3333, res, lat, bcnt);
        check_eq("after_abort_data", res, model(48'h1111_2222_3333));
        check_eq("after_abort_lat", lat, 4);

        // Abort in DONE discards the result
        @(negedge clk);
        iv[1] = 1'b1; idat[1] = 48'h0F0F_F0F0_3C3C;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        wait_valid(1);
        @(negedge clk);
        ab[1] = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_done_valid", ov[1], 1'b0);
        @(negedge clk);
        ab[1] = 1'b0;
        #1;
        check_eq("abort_done_ready", ir[1], 1'b1);

        // Asynchronous reset mid-BUSY
        @(negedge clk);
        iv[1] = 1'b1; idat[1] = 48'h8421_8421_8421;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", bsy[1], 1'b0);
        check_eq("arst_valid", ov[1], 1'b0);
        check_eq("arst_data", odat[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("arst_ready", ir[1], 1'b1);
        xfer(1, 48'h7E7E_8181_5AA5, res, lat, bcnt);
        check_eq("after_arst_data", res, model(48'h7E7E_8181_5AA5));

        // Random streaming on LANES=4
        begin
            logic [31:0] q[$];
            int  sent;
            int  recv;
            int  cyc;
            bit  acc;
            sent = 0; recv = 0; cyc = 0; acc = 0;
            iv[2] = 1'b0; ordy[2] = 1'b0;
            while (recv < 1000 && cyc < 40000) begin
                @(negedge clk);
                cyc++;
                if (acc) iv[2] = 1'b0;
                acc = 0;
                if (!iv[2] && sent < 1000 && $urandom_range(0, 3) != 0) begin
                    iv[2]   = 1'b1;
                    idat[2] = {16'($urandom), $urandom};
                end
                ordy[2] = ($urandom_range(0, 3) != 0);
                #1;
                if (iv[2] && ir[2]) begin
                    q.push_back(model(idat[2]));
                    sent++;
                    acc = 1;
                end
                if (ov[2] && ordy[2]) begin
                    if (q.size() == 0) check_eq("rnd_extra", 1'b1, 1'b0);
                    else check_eq("rnd_data", odat[2], q.pop_front());
                    recv++;
                end
            end
            @(negedge clk);
            iv[2] = 1'b0; ordy[2] = 1'b0;
            check_eq("rnd_recv", recv, 1000);
            check_eq("rnd_sent", sent, 1000);
            check_eq("rnd_left", q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
